mips_run_sequencer: RTL

Synthesizable run controller for the MIPS `datapath_and_controller` core; it replaces fixed bench-side reset and cycle-count sequencing. On a start pulse it holds the core in reset for a parametrised number of cycles, releases it, and counts execution cycles. Execution ends on a cycle budget (timeout) or, when compiled in, on halt detection from the core PC. Sits between the top-level clock/reset and the core's `rst` input; status outputs feed the bench or board LEDs.

---
 rtl/mips_run_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/mips_run_sequencer.sv
// Run controller for the MIPS core: holds core reset after start, then runs until a halt or the cycle budget.
// Optional halt detection (HALT_PC match or stalled PC) is compiled in with `MIPS_RUN_SEQ_HALT_DETECT_EN.
module mips_run_sequencer #(
    parameter int                RST_CYCLES  = 1,
    parameter int                RUN_CYCLES  = 35,
    parameter int                CNT_W       = 16,
    parameter int                PC_W        = 32,
    parameter logic [PC_W-1:0]   HALT_PC     = 32'hFFFF_FFFC,
    parameter int                STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic             launch;
    logic             halt_hit;

    assign launch = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef MIPS_RUN_SEQ_HALT_DETECT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0]    pc_q;
    logic [STALL_W-1:0] stall_cnt;
    logic               pc_same;
    logic               stall_hit;

    // cycle_cnt is 0 only in the first RUN cycle, where pc_q holds no valid history.
    assign pc_same   = (cycle_cnt != '0) && (pc == pc_q);
    assign stall_hit = pc_same && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    assign halt_hit  = (pc == HALT_PC) || stall_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            stall_cnt <= '0;
        end else if (launch) begin
            stall_cnt <= '0;
        end else if (state == S_RUN) begin
            pc_q      <= pc;
            stall_cnt <= pc_same ? stall_cnt + 1'b1 : '0;
        end
    end
`else
    logic unused_halt_cfg;

    assign unused_halt_cfg = (^{pc, HALT_PC}) ^ (STALL_LIMIT != 0);
    assign halt_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            rst_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RESET;
                        halted    <= 1'b0;
                        timeout   <= 1'b0;
                        cycle_cnt <= '0;
                        rst_cnt   <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        state <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    // Halt takes priority over the final budget cycle.
                    if (halt_hit) begin
                        state  <= S_DONE;
                        halted <= 1'b1;
                    end else if (cycle_cnt == CNT_W'(RUN_CYCLES - 1)) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core_rst = (state != S_RUN);
    assign running  = (state == S_RUN);
    assign done     = (state == S_DONE);
endmodule
